// File: rtl/sram_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sram_arb_pkg
// Brief    : FSM encoding, port indices and address window defaults.
// Revision : 1.0
// ============================================================================
package sram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    localparam int unsigned DEF_MEM_BASE  = 1024;
    localparam int unsigned DEF_MEM_LIMIT = 1024 + 2**19 - 1;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter2
// Brief    : Two-way round-robin grant; on a tie the port not served last wins.
// Revision : 1.0
// ============================================================================
module rr_arbiter2
    import sram_arb_pkg::*;
(
    input  logic [1:0] pending,
    input  logic       last,
    output logic       grant
);

    always_comb begin
        grant = PORT0;
        if (pending == 2'b11) begin
            grant = ~last;
        end else if (pending[1]) begin
            grant = PORT1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sram_arbiter
// Brief    : Arbitrates two request ports onto one SRAM controller interface.
// Revision : 1.0
// ============================================================================
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int                 DATA_W    = 32,
    parameter int                 ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]  MEM_BASE  = ADDR_W'(DEF_MEM_BASE),
    parameter logic [ADDR_W-1:0]  MEM_LIMIT = ADDR_W'(DEF_MEM_LIMIT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wrEn0,
    input  logic              rdEn0,
    input  logic [ADDR_W-1:0] address0,
    input  logic [DATA_W-1:0] writeData0,
    output logic [DATA_W-1:0] readData0,
    output logic              done0,
    output logic              err0,
    input  logic              wrEn1,
    input  logic              rdEn1,
    input  logic [ADDR_W-1:0] address1,
    input  logic [DATA_W-1:0] writeData1,
    output logic [DATA_W-1:0] readData1,
    output logic              done1,
    output logic              err1,
    output logic              mem_wrEn,
    output logic              mem_rdEn,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_writeData,
    input  logic [DATA_W-1:0] mem_readData,
    input  logic              mem_ready
);

    // Assert asynchronously, release two edges after rst rises.
    logic [1:0] r_rst_sync;
    logic       w_rst_n;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    arb_state_t        r_state;
    logic              r_owner;
    logic              r_last;
    logic              r_op_wr;
    logic [1:0]        r_done;
    logic [1:0]        r_err;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;
    logic              r_mem_wr;
    logic              r_mem_rd;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;

    logic [1:0]        w_pending;
    logic              w_grant;
    logic              w_sel_wr;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;
    logic              w_in_range;

    assign w_pending = {wrEn1 | rdEn1, wrEn0 | rdEn0};

    rr_arbiter2 u_rr (
        .pending (w_pending),
        .last    (r_last),
        .grant   (w_grant)
    );

    // Write wins when both enables of the granted port are high.
    assign w_sel_wr    = (w_grant == PORT1) ? wrEn1      : wrEn0;
    assign w_sel_addr  = (w_grant == PORT1) ? address1   : address0;
    assign w_sel_wdata = (w_grant == PORT1) ? writeData1 : writeData0;
    assign w_in_range  = (w_sel_addr >= MEM_BASE) && (w_sel_addr <= MEM_LIMIT);

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state     <= IDLE;
            r_owner     <= PORT0;
            r_last      <= PORT1;
            r_op_wr     <= 1'b0;
            r_done      <= 2'b00;
            r_err       <= 2'b00;
            r_rdata0    <= '0;
            r_rdata1    <= '0;
            r_mem_wr    <= 1'b0;
            r_mem_rd    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_done <= 2'b00;
            r_err  <= 2'b00;
            case (r_state)
                IDLE: begin
                    if (|w_pending) begin
                        r_owner     <= w_grant;
                        r_op_wr     <= w_sel_wr;
                        r_mem_addr  <= w_sel_addr;
                        r_mem_wdata <= w_sel_wdata;
                        if (w_in_range) begin
                            r_mem_wr <= w_sel_wr;
                            r_mem_rd <= ~w_sel_wr;
                            r_state  <= BUSY;
                        end else begin
                            r_done[w_grant] <= 1'b1;
                            r_err[w_grant]  <= 1'b1;
                            r_state         <= DONE;
                        end
                    end
                end
                BUSY: begin
                    if (mem_ready) begin
                        r_mem_wr <= 1'b0;
                        r_mem_rd <= 1'b0;
                        if (!r_op_wr) begin
                            if (r_owner == PORT1) begin
                                r_rdata1 <= mem_readData;
                            end else begin
                                r_rdata0 <= mem_readData;
                            end
                        end
                        r_done[r_owner] <= 1'b1;
                        r_state         <= DONE;
                    end
                end
                DONE: begin
                    r_last  <= r_owner;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign readData0     = r_rdata0;
    assign readData1     = r_rdata1;
    assign done0         = r_done[0];
    assign done1         = r_done[1];
    assign err0          = r_err[0];
    assign err1          = r_err[1];
    assign mem_wrEn      = r_mem_wr;
    assign mem_rdEn      = r_mem_rd;
    assign mem_address   = r_mem_addr;
    assign mem_writeData = r_mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_arbiter
// Brief    : Directed vector bench for sram_arbiter with a latency-programmable
//            SRAM controller model.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wrEn0 = 1'b0, rdEn0 = 1'b0, wrEn1 = 1'b0, rdEn1 = 1'b0;
    logic [31:0] address0 = '0, writeData0 = '0, address1 = '0, writeData1 = '0;
    logic [31:0] readData0, readData1, mem_address, mem_writeData;
    logic [31:0] mem_readData = '0;
    logic        done0, err0, done1, err1, mem_wrEn, mem_rdEn, mem_ready;

    int   checks   = 0;
    int   failures = 0;
    int   lat      = 1;
    int   busy_cnt = 0;
    logic stray    = 1'b0;

    sram_arbiter dut (
        .clk(clk), .rst(rst),
        .wrEn0(wrEn0), .rdEn0(rdEn0), .address0(address0), .writeData0(writeData0),
        .readData0(readData0), .done0(done0), .err0(err0),
        .wrEn1(wrEn1), .rdEn1(rdEn1), .address1(address1), .writeData1(writeData1),
        .readData1(readData1), .done1(done1), .err1(err1),
        .mem_wrEn(mem_wrEn), .mem_rdEn(mem_rdEn), .mem_address(mem_address),
        .mem_writeData(mem_writeData), .mem_readData(mem_readData), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    // Controller model: strobes ready in the lat-th cycle of a held request.
    always @(posedge clk) busy_cnt <= (mem_wrEn || mem_rdEn) ? busy_cnt + 1 : 0;
    assign mem_ready = stray || ((mem_wrEn || mem_rdEn) && (busy_cnt == lat - 1));

    typedef struct {
        logic        port;
        logic        wr;
        logic        rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          lat;
        logic        exp_err;
        int          exp_wcyc;
        int          exp_rcyc;
        int          exp_cycles;
        logic [31:0] exp_rd0;
        logic [31:0] exp_rd1;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic port, input logic wr, input logic rd,
                         input logic [31:0] a, input logic [31:0] d);
        if (port) begin
            wrEn1 = wr; rdEn1 = rd; address1 = a; writeData1 = d;
        end else begin
            wrEn0 = wr; rdEn0 = rd; address0 = a; writeData0 = d;
        end
    endtask

    task automatic drop_all();
        wrEn0 = 1'b0; rdEn0 = 1'b0; wrEn1 = 1'b0; rdEn1 = 1'b0;
    endtask

    task automatic apply_reset();
        drop_all();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    // One transaction; cycles are counted with the request cycle as cycle 1.
    task automatic run_vec(input vec_t v, input int idx);
        int          n = 0, wc = 0, rc = 0, other = 0;
        logic        got_done = 1'b0, got_err = 1'b0;
        logic [31:0] a_seen = '0, d_seen = '0;
        lat = v.lat;
        mem_readData = v.rdata;
        @(posedge clk); #1;
        drive(v.port, v.wr, v.rd, v.addr, v.wdata);
        while (!got_done && n < 100) begin
            @(negedge clk);
            n++;
            if (mem_wrEn) wc++;
            if (mem_rdEn) rc++;
            if ((mem_wrEn || mem_rdEn) && (wc + rc == 1)) begin
                a_seen = mem_address;
                d_seen = mem_writeData;
            end
            if (v.port ? done0 : done1) other++;
            if (v.port ? done1 : done0) begin
                got_done = 1'b1;
                got_err  = v.port ? err1 : err0;
            end
        end
        chk($sformatf("v%0d_done_seen", idx), 64'(got_done), 64'd1);
        chk($sformatf("v%0d_cycles", idx), 64'(n), 64'(v.exp_cycles));
        chk($sformatf("v%0d_err", idx), 64'(got_err), 64'(v.exp_err));
        chk($sformatf("v%0d_wr_cycles", idx), 64'(wc), 64'(v.exp_wcyc));
        chk($sformatf("v%0d_rd_cycles", idx), 64'(rc), 64'(v.exp_rcyc));
        chk($sformatf("v%0d_other_done", idx), 64'(other), 64'd0);
        if (!v.exp_err) begin
            chk($sformatf("v%0d_mem_addr", idx), 64'(a_seen), 64'(v.addr));
            if (v.wr) chk($sformatf("v%0d_mem_wdata", idx), 64'(d_seen), 64'(v.wdata));
        end
        @(posedge clk); #1;
        drop_all();
        @(negedge clk);
        chk($sformatf("v%0d_done_single", idx), {62'd0, done0, done1}, 64'd0);
        chk($sformatf("v%0d_rd0", idx), 64'(readData0), 64'(v.exp_rd0));
        chk($sformatf("v%0d_rd1", idx), 64'(readData1), 64'(v.exp_rd1));
    endtask

    initial begin
        int   order[4];
        int   t_done[4];
        int   k;
        int   n;
        logic saw_done1;
        vec_t tail;

        //            port wr    rd    addr          wdata         rdata         lat err  wc rc cyc rd0           rd1
        vecs[0] = '{1'b0, 1'b0, 1'b1, 32'd1028,     32'h0,        32'hDEADBEEF, 8, 1'b0, 0, 8, 10, 32'hDEADBEEF, 32'h0};
        vecs[1] = '{1'b0, 1'b1, 1'b1, 32'd2048,     32'h12345678, 32'hFFFFFFFF, 3, 1'b0, 3, 0, 5,  32'hDEADBEEF, 32'h0};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 32'h100,      32'hAAAA5555, 32'h0,        1, 1'b1, 0, 0, 2,  32'hDEADBEEF, 32'h0};
        vecs[3] = '{1'b1, 1'b0, 1'b1, 32'h400,      32'h0,        32'hA5A50001, 1, 1'b0, 0, 1, 3,  32'hDEADBEEF, 32'hA5A50001};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 32'h803FF,    32'h0,        32'h0BADF00D, 2, 1'b0, 0, 2, 4,  32'h0BADF00D, 32'hA5A50001};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 32'h80400,    32'h0,        32'h11111111, 1, 1'b1, 0, 0, 2,  32'h0BADF00D, 32'hA5A50001};
        vecs[6] = '{1'b1, 1'b0, 1'b1, 32'h3FF,      32'h0,        32'h33333333, 1, 1'b1, 0, 0, 2,  32'h0BADF00D, 32'hA5A50001};
        vecs[7] = '{1'b1, 1'b1, 1'b0, 32'h1000,     32'hCAFEF00D, 32'h22222222, 4, 1'b0, 4, 0, 6,  32'h0BADF00D, 32'hA5A50001};

        // Values held during reset.
        repeat (2) @(negedge clk);
        chk("rst_strobes", {58'd0, mem_wrEn, mem_rdEn, done0, done1, err0, err1}, 64'd0);
        chk("rst_rdata", {readData0, readData1}, 64'd0);
        chk("rst_mem_payload", {mem_address, mem_writeData}, 64'd0);
        @(posedge clk); #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // Contention from reset: tie goes to port 0, then strict alternation.
        apply_reset();
        lat = 2;
        mem_readData = 32'h0F0F0F0F;
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b1, 32'h500, 32'h0);
        drive(1'b1, 1'b0, 1'b1, 32'h600, 32'h0);
        k = 0;
        n = 0;
        while (k < 4 && n < 200) begin
            @(negedge clk);
            n++;
            if (done0 || done1) begin
                order[k]  = done1 ? 1 : 0;
                t_done[k] = n;
                k++;
            end
        end
        @(posedge clk); #1;
        drop_all();
        chk("cont_completions", 64'(k), 64'd4);
        if (k == 4) begin
            chk("cont_order", {32'(order[0]), 8'(order[1]), 8'(order[2]), 16'(order[3])},
                {32'd0, 8'd1, 8'd0, 16'd1});
            for (int i = 0; i < 3; i++)
                chk($sformatf("cont_gap%0d", i), 64'(t_done[i+1] - t_done[i]), 64'(lat + 2));
        end
        repeat (2) @(posedge clk);
        #1;

        // Reset three cycles into a port-1 read.
        lat = 20;
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 1'b1, 32'h700, 32'h0);
        repeat (4) @(negedge clk);
        chk("mid_busy_active", 64'(mem_rdEn), 64'd1);
        #1 rst = 1'b0;
        #1;
        chk("mid_rst_rden_low", {62'd0, mem_rdEn, mem_wrEn}, 64'd0);
        drop_all();
        lat = 1;
        mem_readData = 32'h0F0F0F0F;
        saw_done1 = 1'b0;
        drive(1'b0, 1'b0, 1'b1, 32'h800, 32'h0);
        drive(1'b1, 1'b0, 1'b1, 32'h900, 32'h0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        chk("rst_exit_no_grant_edge1", {62'd0, mem_rdEn, mem_wrEn}, 64'd0);
        n = 0;
        while (!done0 && n < 20) begin
            @(negedge clk);
            n++;
            if (done1) saw_done1 = 1'b1;
        end
        chk("rst_tie_port0_done", 64'(done0), 64'd1);
        chk("rst_no_done1", 64'(saw_done1), 64'd0);
        @(posedge clk); #1;
        drop_all();
        repeat (2) @(posedge clk);

        // Stray controller strobe while idle.
        #1;
        mem_readData = 32'h5555AAAA;
        stray = 1'b1;
        @(posedge clk); #1;
        stray = 1'b0;
        @(negedge clk);
        chk("stray_no_pulse", {60'd0, done0, done1, err0, err1}, 64'd0);
        chk("stray_no_mem", {62'd0, mem_rdEn, mem_wrEn}, 64'd0);
        chk("stray_rdata", {readData0, readData1}, {32'h0F0F0F0F, 32'h0});
        tail = '{1'b1, 1'b0, 1'b1, 32'h2000, 32'h0, 32'h77777777, 2, 1'b0, 0, 2, 4,
                 32'h0F0F0F0F, 32'h77777777};
        run_vec(tail, 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
